rgb_pwm_blink: RTL and testbench

RGB_PWM_BLINK -- requirements
Module: rgb_pwm_blink

---
 rtl/rgb_pwm_blink.sv | 158 +++++++++++++++
 tb/tb_rgb_pwm_blink.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_blink.sv
// Multi-channel LED PWM driver with off/on/blink/breathe modes and a single-slot config shadow.
// Breathe support is compiled in only when RGB_BREATHE_EN is defined; otherwise mode 11 reads as off.
module rgb_pwm_blink #(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned DIV_BITS = 25,
  localparam int unsigned CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                int_osc,
  input  logic                rstn,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic [NUM_CH-1:0]   pwm_out,
  output logic                blink_phase
);

  typedef enum logic [1:0] {ModeOff, ModeOn, ModeBlink, ModeBreathe} mode_e;

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DIV_BITS-1:0] div_cnt_q, div_cnt_d;
  logic                blink_q, blink_d;
  logic                pend_q, pend_d;
  logic [CW-1:0]       pend_ch_q, pend_ch_d;
  mode_e               pend_mode_q, pend_mode_d;
  logic [PWM_BITS-1:0] pend_duty_q, pend_duty_d;
  mode_e               mode_q [NUM_CH];
  mode_e               mode_d [NUM_CH];
  logic [PWM_BITS-1:0] duty_q [NUM_CH];
  logic [PWM_BITS-1:0] duty_d [NUM_CH];
  logic [PWM_BITS-1:0] eff_duty [NUM_CH];
  logic [NUM_CH-1:0]   pwm_out_q, pwm_out_d;
  logic                pwm_wrap, accept, transfer;

`ifdef RGB_BREATHE_EN
  logic [PWM_BITS-1:0] breath_lvl_q, breath_lvl_d;
  logic                breath_up_q, breath_up_d;

  // Triangle ramp: reverse on the step that reaches an end, so neither end is held.
  always_comb begin
    breath_lvl_d = breath_lvl_q;
    breath_up_d  = breath_up_q;
    if (div_cnt_q[DIV_BITS-PWM_BITS-1:0] == '1) begin
      if (breath_up_q) begin
        if (breath_lvl_q == '1) begin
          breath_lvl_d = breath_lvl_q - PWM_BITS'(1);
          breath_up_d  = 1'b0;
        end else begin
          breath_lvl_d = breath_lvl_q + PWM_BITS'(1);
        end
      end else begin
        if (breath_lvl_q == '0) begin
          breath_lvl_d = breath_lvl_q + PWM_BITS'(1);
          breath_up_d  = 1'b1;
        end else begin
          breath_lvl_d = breath_lvl_q - PWM_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge int_osc or negedge rstn) begin
    if (!rstn) begin
      breath_lvl_q <= '0;
      breath_up_q  <= 1'b1;
    end else begin
      breath_lvl_q <= breath_lvl_d;
      breath_up_q  <= breath_up_d;
    end
  end
`endif

  always_comb begin
    pwm_wrap  = (pwm_cnt_q == '1);
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    div_cnt_d = div_cnt_q + DIV_BITS'(1);
    blink_d   = blink_q ^ (div_cnt_q == '1);
    accept    = cfg_valid & ~pend_q;
    // An accept can only set pend_q at the edge, so a wrap in the accept cycle is never used.
    transfer  = pend_q & pwm_wrap;

    pend_d      = pend_q;
    pend_ch_d   = pend_ch_q;
    pend_mode_d = pend_mode_q;
    pend_duty_d = pend_duty_q;
    if (accept) begin
      pend_d      = 1'b1;
      pend_ch_d   = cfg_ch;
      pend_mode_d = mode_e'(cfg_mode);
      pend_duty_d = cfg_duty;
    end else if (transfer) begin
      pend_d = 1'b0;
    end

    mode_d = mode_q;
    duty_d = duty_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (transfer && (pend_ch_q == CW'(i))) begin
        mode_d[i] = pend_mode_q;
        duty_d[i] = pend_duty_q;
      end
    end
  end

  always_comb begin
    pwm_out_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      eff_duty[i] = '0;
      case (mode_q[i])
        ModeOn:    eff_duty[i] = duty_q[i];
        ModeBlink: eff_duty[i] = blink_q ? duty_q[i] : '0;
`ifdef RGB_BREATHE_EN
        ModeBreathe: eff_duty[i] = PWM_BITS'(((2*PWM_BITS)'(duty_q[i]) *
                                              (2*PWM_BITS)'(breath_lvl_q)) >> PWM_BITS);
`endif
        default:   eff_duty[i] = '0;
      endcase
      pwm_out_d[i] = (pwm_cnt_q < eff_duty[i]);
    end
  end

  always_ff @(posedge int_osc or negedge rstn) begin
    if (!rstn) begin
      pwm_cnt_q   <= '0;
      div_cnt_q   <= '0;
      blink_q     <= 1'b0;
      pend_q      <= 1'b0;
      pend_ch_q   <= '0;
      pend_mode_q <= ModeOff;
      pend_duty_q <= '0;
      pwm_out_q   <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        mode_q[i] <= ModeOff;
        duty_q[i] <= '0;
      end
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      div_cnt_q   <= div_cnt_d;
      blink_q     <= blink_d;
      pend_q      <= pend_d;
      pend_ch_q   <= pend_ch_d;
      pend_mode_q <= pend_mode_d;
      pend_duty_q <= pend_duty_d;
      pwm_out_q   <= pwm_out_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        mode_q[i] <= mode_d[i];
        duty_q[i] <= duty_d[i];
      end
    end
  end

  assign cfg_ready   = ~pend_q;
  assign pwm_out     = pwm_out_q;
  assign blink_phase = blink_q;

endmodule

// File: tb/tb_rgb_pwm_blink.sv
// Randomized and directed bench for rgb_pwm_blink against a cycle-count based reference model.
module tb_rgb_pwm_blink;

  logic       int_osc = 1'b0;
  logic       rstn;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [3:0] cfg_duty;
  logic [2:0] pwm_out;
  logic       blink_phase;

  rgb_pwm_blink #(
    .NUM_CH   (3),
    .PWM_BITS (4),
    .DIV_BITS (6)
  ) dut (
    .int_osc     (int_osc),
    .rstn        (rstn),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_mode    (cfg_mode),
    .cfg_duty    (cfg_duty),
    .pwm_out     (pwm_out),
    .blink_phase (blink_phase)
  );

  always #5 int_osc = ~int_osc;

  int checks = 0;
  int errors = 0;

  // Model: everything periodic is derived from t, the number of clock edges since reset release.
  int unsigned t;
  int          m_mode [3];
  int          m_duty [3];
  bit          m_pend;
  int          m_pch, m_pmode, m_pduty;
  bit          last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_pend = 0;
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = 0;
      m_duty[i] = 0;
    end
  endtask

  function automatic int breath_at(input int unsigned tt);
    int n;
    n = (tt / 4) % 30;
    return (n <= 15) ? n : 30 - n;
  endfunction

  function automatic int eff_of(input int ch, input int unsigned tt);
    case (m_mode[ch])
      1: return m_duty[ch];
      2: return ((tt / 64) % 2 == 1) ? m_duty[ch] : 0;
`ifdef RGB_BREATHE_EN
      3: return (m_duty[ch] * breath_at(tt)) / 16;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic tick();
    logic [2:0] exp_pwm;
    bit acc, xfer;
    for (int i = 0; i < 3; i++) exp_pwm[i] = ((t % 16) < eff_of(i, t));
    acc  = cfg_valid && !m_pend;
    xfer = m_pend && (t % 16 == 15);
    @(posedge int_osc);
    t++;
    if (xfer) begin
      if (m_pch < 3) begin
        m_mode[m_pch] = m_pmode;
        m_duty[m_pch] = m_pduty;
      end
      m_pend = 0;
    end
    if (acc) begin
      m_pend  = 1;
      m_pch   = int'(cfg_ch);
      m_pmode = int'(cfg_mode);
      m_pduty = int'(cfg_duty);
    end
    last_acc = acc;
    #1;
    chk("pwm_out", 32'(pwm_out), 32'(exp_pwm));
    chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
    chk("blink_phase", 32'(blink_phase), (t / 64) % 2);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write(input logic [1:0] ch, input logic [1:0] mode, input logic [3:0] duty);
    int n;
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_mode  = mode;
    cfg_duty  = duty;
    n = 0;
    last_acc = 0;
    while (!last_acc && n < 64) begin
      tick();
      n++;
    end
    chk("write_accept", 32'(last_acc), 32'd1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_pend && n < 64) begin
      tick();
      n++;
    end
    chk("pend_drain", 32'(m_pend), 32'd0);
  endtask

  initial begin
    int cnt;
    rstn      = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_mode  = '0;
    cfg_duty  = '0;
    model_reset();

    // Reset values must hold before any clock edge.
    #2;
    chk("rst_pwm_out", 32'(pwm_out), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_blink", 32'(blink_phase), 32'd0);
    @(posedge int_osc);
    @(posedge int_osc);
    #1;
    chk("rst_hold_pwm_out", 32'(pwm_out), 32'd0);
    rstn = 1'b1;
    model_reset();

    // ch0 on, duty 4: check the steady-state high count over one PWM period.
    write(2'd0, 2'b01, 4'd4);
    run(20);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      cnt += int'(pwm_out[0]);
    end
    chk("ch0_high_count", cnt, 32'd4);

    // ch1 blink, full-scale duty across several blink phases.
    write(2'd1, 2'b10, 4'd15);
    run(200);

    // cfg_valid held high with fresh data after every accept.
    cfg_valid = 1'b1;
    cfg_ch    = 2'($urandom_range(0, 3));
    cfg_mode  = 2'($urandom_range(0, 3));
    cfg_duty  = 4'($urandom_range(0, 15));
    for (int i = 0; i < 80; i++) begin
      tick();
      if (last_acc) begin
        cfg_ch   = 2'($urandom_range(0, 3));
        cfg_mode = 2'($urandom_range(0, 3));
        cfg_duty = 4'($urandom_range(0, 15));
      end
    end
    cfg_valid = 1'b0;
    wait_idle();

    // ch2 breathe over more than two triangle periods.
    write(2'd2, 2'b11, 4'd15);
    run(300);

    // Out-of-range channel is accepted and dropped.
    write(2'd3, 2'b01, 4'd15);
    run(40);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_mode  = 2'($urandom_range(0, 3));
      cfg_duty  = 4'($urandom_range(0, 15));
      tick();
    end
    cfg_valid = 1'b0;
    wait_idle();

    // Mid-operation reset with a write pending while ch0 is driving high.
    write(2'd0, 2'b01, 4'd15);
    wait_idle();
    run(1);
    write(2'd1, 2'b01, 4'd7);
    chk("pre_rst_ch0_high", 32'(pwm_out[0]), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_pwm_out", 32'(pwm_out), 32'd0);
    chk("async_rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("async_rst_blink", 32'(blink_phase), 32'd0);
    @(posedge int_osc);
    #1;
    rstn = 1'b1;
    model_reset();
    run(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
